// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline control unit: sequencer states and defaults.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam int PERF_W_DEFAULT     = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        EX_WAIT  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_control_unit_load_use.sv
// Load-use hazard detector: EX holds a load whose destination is read by ID.
module load_use_detector
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_reg_wren,
    output logic                  hazard
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    always_comb begin
        hazard = ex_is_load && ex_reg_wren && (ex_rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: owns every pipeline-register
// write enable, sequences multi-cycle MEM and EX operations, counts stalls.
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int PERF_W     = PERF_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_reg_wren,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mc_req,
    input  logic                  mc_done,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  mem_start,
    output logic                  mc_start,
    output logic                  pc_wren,
    output logic                  if_id_wren,
    output logic                  id_ex_wren,
    output logic                  ex_mem_wren,
    output logic                  mem_wb_wren,
    output logic                  if_id_bubble,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  mem_wb_bubble,
    output logic [PERF_W-1:0]     stall_cycles
);

    ctrl_state_t state, next_state;
    logic        load_use;

    load_use_detector #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .ex_reg_wren (ex_reg_wren),
        .hazard      (load_use)
    );

    // Output decode and next-state selection; everything idles low in reset
    always_comb begin
        next_state    = state;
        mem_start     = 1'b0;
        mc_start      = 1'b0;
        pc_wren       = 1'b0;
        if_id_wren    = 1'b0;
        id_ex_wren    = 1'b0;
        ex_mem_wren   = 1'b0;
        mem_wb_wren   = 1'b0;
        if_id_bubble  = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        if (reset_n) begin
            // An advance is needed in RUN (no request), on mem_ready without
            // a pending EX op, and on mc_done.
            logic advance;
            advance = 1'b0;
            case (state)
                RUN: begin
                    if (mem_req) begin
                        // MEM has priority; a concurrent EX request waits its turn
                        mem_start     = 1'b1;
                        mem_wb_wren   = 1'b1;
                        mem_wb_bubble = 1'b1;
                        next_state    = MEM_WAIT;
                    end else if (ex_mc_req) begin
                        mc_start      = 1'b1;
                        ex_mem_wren   = 1'b1;
                        ex_mem_bubble = 1'b1;
                        mem_wb_wren   = 1'b1;
                        next_state    = EX_WAIT;
                    end else begin
                        advance = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        mem_wb_wren   = 1'b1;
                        mem_wb_bubble = 1'b1;
                    end else if (ex_mc_req) begin
                        // MEM retires into WB while EX launches its unit
                        mc_start      = 1'b1;
                        ex_mem_wren   = 1'b1;
                        ex_mem_bubble = 1'b1;
                        mem_wb_wren   = 1'b1;
                        next_state    = EX_WAIT;
                    end else begin
                        advance    = 1'b1;
                        next_state = RUN;
                    end
                end
                EX_WAIT: begin
                    // MEM holds a bubble here, so mem_req is not looked at
                    if (!mc_done) begin
                        ex_mem_wren   = 1'b1;
                        ex_mem_bubble = 1'b1;
                        mem_wb_wren   = 1'b1;
                    end else begin
                        advance    = 1'b1;
                        next_state = RUN;
                    end
                end
                default: next_state = RUN;
            endcase
            if (advance) begin
                pc_wren     = 1'b1;
                if_id_wren  = 1'b1;
                id_ex_wren  = 1'b1;
                ex_mem_wren = 1'b1;
                mem_wb_wren = 1'b1;
                // A taken branch squashes the wrong-path instructions, which
                // also makes any load-use match against them irrelevant.
                if (ex_branch_taken) begin
                    if_id_bubble = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_wren      = 1'b0;
                    if_id_wren   = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
        end
    end

    // State register and saturating stall counter, synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= RUN;
            stall_cycles <= '0;
        end else begin
            state <= next_state;
            if (!pc_wren && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed self-checking bench for pipeline_control_unit.
module tb_pipeline_control_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_reg_wren;
    logic        ex_branch_taken, ex_mc_req, mc_done, mem_req, mem_ready;
    logic        mem_start, mc_start, pc_wren, if_id_wren, id_ex_wren;
    logic        ex_mem_wren, mem_wb_wren;
    logic        if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
    logic [31:0] stall_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    // Output vector: {mem_start, mc_start, pc, if_id, id_ex, ex_mem, mem_wb
    //                 wren, if_id, id_ex, ex_mem, mem_wb bubble}
    localparam logic [10:0] O_RST  = 11'b00_00000_0000;
    localparam logic [10:0] O_ADV  = 11'b00_11111_0000;
    localparam logic [10:0] O_LU   = 11'b00_00111_0100;
    localparam logic [10:0] O_BR   = 11'b00_11111_1100;
    localparam logic [10:0] O_MLN  = 11'b10_00001_0001;
    localparam logic [10:0] O_MWT  = 11'b00_00001_0001;
    localparam logic [10:0] O_MCL  = 11'b01_00011_0010;
    localparam logic [10:0] O_EXW  = 11'b00_00011_0010;

    pipeline_control_unit dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_wren(ex_reg_wren),
        .ex_branch_taken(ex_branch_taken), .ex_mc_req(ex_mc_req),
        .mc_done(mc_done), .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_start(mem_start), .mc_start(mc_start),
        .pc_wren(pc_wren), .if_id_wren(if_id_wren), .id_ex_wren(id_ex_wren),
        .ex_mem_wren(ex_mem_wren), .mem_wb_wren(mem_wb_wren),
        .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
        .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Next cycle: inputs change 1 time unit after the rising edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, then compare well before the next edge
    task automatic chk_out(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        #2;
        obs = {mem_start, mc_start, pc_wren, if_id_wren, id_ex_wren,
               ex_mem_wren, mem_wb_wren, if_id_bubble, id_ex_bubble,
               ex_mem_bubble, mem_wb_bubble};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic [31:0] exp);
        n_assert++;
        assert (stall_cycles === exp) else begin
            n_fail++;
            $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp);
        end
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0; ex_reg_wren = 0;
        ex_branch_taken = 0; ex_mc_req = 0; mc_done = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        clr();
        reset_n = 0;
        nxt();
        reset_n = 1;
    endtask

    initial begin
        clr();
        reset_n = 0;
        #1;
        // Reset: outputs low while asserted, counter cleared on the edge
        chk_out("reset_outputs", O_RST);
        nxt();
        chk_stall("reset_stall", 0);
        reset_n = 1;

        // Idle RUN for 10 cycles
        for (int i = 0; i < 10; i++) begin
            chk_out("idle_adv", O_ADV);
            nxt();
        end
        chk_stall("idle_stall", 0);

        // Load x5 in EX, ID reads x5 through rs2
        ex_is_load = 1; ex_reg_wren = 1; ex_rd = 5'd5; id_uses_rs2 = 1; id_rs2 = 5'd5;
        chk_out("lu_rs2", O_LU);
        nxt();
        clr();
        chk_out("lu_after", O_ADV);
        chk_stall("lu_stall", 1);
        nxt();
        // Same load to x0 reading x0: never a hazard
        ex_is_load = 1; ex_reg_wren = 1; ex_rd = 5'd0; id_uses_rs2 = 1; id_rs2 = 5'd0;
        chk_out("lu_x0", O_ADV);
        nxt();
        // rs1 match, but ex_reg_wren=0: no hazard; then with wren: hazard
        clr();
        ex_is_load = 1; ex_rd = 5'd9; id_uses_rs1 = 1; id_rs1 = 5'd9;
        chk_out("lu_nowren", O_ADV);
        nxt();
        ex_reg_wren = 1;
        chk_out("lu_rs1", O_LU);
        nxt();
        clr();
        chk_stall("lu_stall2", 2);

        // MEM access with mem_ready 3 cycles after mem_start
        do_reset();
        chk_stall("mem_rst_stall", 0);
        mem_req = 1;
        chk_out("mem_launch", O_MLN);
        nxt();
        chk_out("mem_wait1", O_MWT);
        nxt();
        chk_out("mem_wait2", O_MWT);
        nxt();
        mem_ready = 1; mem_req = 0;
        chk_out("mem_done", O_ADV);
        nxt();
        mem_ready = 0;
        chk_out("mem_run", O_ADV);
        chk_stall("mem_stall", 3);
        nxt();

        // MEM then multi-cycle EX: mem_ready after 2, mc_done after 4
        do_reset();
        mem_req = 1; ex_mc_req = 1;
        chk_out("mx_launch", O_MLN);
        nxt();
        chk_out("mx_wait", O_MWT);
        nxt();
        mem_ready = 1;
        chk_out("mx_mc_start", O_MCL);
        nxt();
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            chk_out("mx_ex_wait", O_EXW);
            nxt();
        end
        mc_done = 1; mem_req = 0; ex_mc_req = 0;
        chk_out("mx_done", O_ADV);
        nxt();
        mc_done = 0;
        chk_out("mx_run", O_ADV);
        chk_stall("mx_stall", 6);
        nxt();

        // Plain EX multi-cycle from RUN
        do_reset();
        ex_mc_req = 1;
        chk_out("ex_launch", O_MCL);
        nxt();
        mem_req = 1;
        chk_out("ex_wait_ignores_mem", O_EXW);
        nxt();
        mem_req = 0; mc_done = 1; ex_mc_req = 0;
        chk_out("ex_done", O_ADV);
        nxt();
        clr();
        chk_stall("ex_stall", 2);

        // Taken branch wins over a load-use match
        do_reset();
        ex_branch_taken = 1; ex_is_load = 1; ex_reg_wren = 1; ex_rd = 5'd7;
        id_uses_rs1 = 1; id_rs1 = 5'd7;
        chk_out("br_over_lu", O_BR);
        nxt();
        clr();
        chk_stall("br_stall", 0);

        // Reset mid-MEM_WAIT, then a stray mem_ready in RUN
        do_reset();
        mem_req = 1;
        chk_out("rw_launch", O_MLN);
        nxt();
        chk_out("rw_wait", O_MWT);
        nxt();
        mem_req = 0; reset_n = 0;
        chk_out("rw_in_reset", O_RST);
        nxt();
        reset_n = 1; mem_ready = 1;
        chk_out("rw_stray_ready", O_ADV);
        chk_stall("rw_stall0", 0);
        nxt();
        mem_ready = 0;
        chk_out("rw_run", O_ADV);
        chk_stall("rw_stall1", 0);
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
